// File: rtl/pwm_multi_unit.sv
// Multi-channel PWM: shared period counter, per-channel registered comparators, config writes staged until the period boundary.
// Latency: pwm_out lags pwm_count by one cycle; config writes take effect at the next load event (counter wrap to 0).
// Backpressure: none; one config write accepted every cycle, out-of-range addresses dropped. Optional macro: PWM_CENTER_ALIGN_EN.
module pwm_multi_unit #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int AW       = $clog2(CHANNELS + 1)
) (
    input  logic                pwm_clk,
    input  logic                pwm_reset,
    input  logic                cfg_we,
    input  logic [AW-1:0]       cfg_addr,
    input  logic [WIDTH-1:0]    cfg_data,
    input  logic [CHANNELS-1:0] pwm_en,
    input  logic                pwm_center,
    output logic                pwm_period,
    output logic [WIDTH-1:0]    pwm_count,
    output logic [CHANNELS-1:0] pwm_out
);

    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    r_range_pend;
    logic [WIDTH-1:0]    r_range_sh;
    logic [WIDTH-1:0]    r_duty_pend [CHANNELS];
    logic [WIDTH-1:0]    r_duty_sh   [CHANNELS];
    logic [CHANNELS-1:0] r_out;
    logic                r_period;
    logic                r_restart;

    logic                w_load;
    logic [WIDTH-1:0]    w_count_nxt;

`ifdef PWM_CENTER_ALIGN_EN
    logic                r_dir;        // 0 = counting up, 1 = counting down
    logic                r_center_sh;  // mode latched for the current period
    logic                w_dir_nxt;
`else
    logic                w_center_unused;
    assign w_center_unused = pwm_center;
`endif

    // Config port: stage writes into pending registers only; shadows are loaded at the boundary.
    always_ff @(posedge pwm_clk or posedge pwm_reset) begin
        if (pwm_reset) begin
            r_range_pend <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_pend[i] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_addr == AW'(CHANNELS)) begin
                r_range_pend <= cfg_data;
            end
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_addr == AW'(i)) begin
                    r_duty_pend[i] <= cfg_data;
                end
            end
        end
    end

    // Next counter value and period-boundary (load event) detection.
    always_comb begin
        w_load      = 1'b0;
        w_count_nxt = r_count + WIDTH'(1);
`ifdef PWM_CENTER_ALIGN_EN
        w_dir_nxt   = r_dir;
        if (r_restart) begin
            w_load = 1'b1;
        end else if (r_center_sh && (r_range_sh != '0)) begin
            if (!r_dir) begin
                if (r_count >= r_range_sh) begin
                    // A range of 1 has no down leg: the period is just 0,1.
                    if (r_range_sh == WIDTH'(1)) begin
                        w_load = 1'b1;
                    end else begin
                        w_count_nxt = r_range_sh - WIDTH'(1);
                        w_dir_nxt   = 1'b1;
                    end
                end
            end else begin
                if (r_count <= WIDTH'(1)) begin
                    w_load = 1'b1;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end else if (r_count >= r_range_sh) begin
            w_load = 1'b1;
        end
        if (w_load) begin
            w_count_nxt = '0;
            w_dir_nxt   = 1'b0;
        end
`else
        if (r_restart || (r_count >= r_range_sh)) begin
            w_load      = 1'b1;
            w_count_nxt = '0;
        end
`endif
    end

    // Counter, restart flag, period pulse and shadow loading on the load event.
    always_ff @(posedge pwm_clk or posedge pwm_reset) begin
        if (pwm_reset) begin
            r_count    <= '0;
            r_range_sh <= '1;
            r_period   <= 1'b0;
            r_restart  <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty_sh[i] <= '0;
            end
`ifdef PWM_CENTER_ALIGN_EN
            r_dir       <= 1'b0;
            r_center_sh <= 1'b0;
`endif
        end else begin
            r_count   <= w_count_nxt;
            r_period  <= w_load;
            r_restart <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            r_dir     <= w_dir_nxt;
`endif
            if (w_load) begin
                r_range_sh <= r_range_pend;
                for (int i = 0; i < CHANNELS; i++) begin
                    r_duty_sh[i] <= r_duty_pend[i];
                end
`ifdef PWM_CENTER_ALIGN_EN
                r_center_sh <= pwm_center;
`endif
            end
        end
    end

    // Registered per-channel compare; enable gates the output without touching counter state.
    always_ff @(posedge pwm_clk or posedge pwm_reset) begin
        if (pwm_reset) begin
            r_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_out[i] <= pwm_en[i] && (r_count < r_duty_sh[i]);
            end
        end
    end

    assign pwm_period = r_period;
    assign pwm_count  = r_count;
    assign pwm_out    = r_out;

endmodule

// File: tb/tb_pwm_multi_unit.sv
// Directed bench for pwm_multi_unit: edge-aligned periods, duty extremes, staged config writes,
// range 0, enable gating and mid-period reset; center-aligned counting when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multi_unit;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int AW = $clog2(CH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [W-1:0]  cfg_data = '0;
    logic [CH-1:0] en = '1;
    logic          center = 1'b0;
    logic          period;
    logic [W-1:0]  count;
    logic [CH-1:0] out;

    int total = 0;
    int bad   = 0;
    int range_m;
    int duty_m [CH];
    int cseq   [8];

    pwm_multi_unit #(.WIDTH(W), .CHANNELS(CH)) dut (
        .pwm_clk    (clk),
        .pwm_reset  (rst),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .pwm_en     (en),
        .pwm_center (center),
        .pwm_period (period),
        .pwm_count  (count),
        .pwm_out    (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the write edge.
    task automatic wr(input int a, input int d);
        cfg_addr = AW'(a);
        cfg_data = W'(d);
        cfg_we   = 1'b1;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // Advance to the next falling edge with pwm_period high, within a cycle budget.
    task automatic wait_period(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (period !== 1'b1 && n < budget);
        chk("period_seen", period, 1);
    endtask

    // Starting at the first cycle of a period, check one full edge-aligned period.
    task automatic check_period(input string tag, input int h0, input int h1, input int h2, input int h3);
        int hi   [CH];
        int hexp [CH];
        int prev;
        logic [CH-1:0] ev;
        hexp[0] = h0; hexp[1] = h1; hexp[2] = h2; hexp[3] = h3;
        for (int i = 0; i < CH; i++) hi[i] = 0;
        for (int k = 0; k <= range_m; k++) begin
            prev = (k == 0) ? range_m : k - 1;
            for (int i = 0; i < CH; i++) ev[i] = en[i] && (prev < duty_m[i]);
            chk($sformatf("%s_cnt%0d", tag, k), count, k);
            chk($sformatf("%s_per%0d", tag, k), period, (k == 0));
            chk($sformatf("%s_out%0d", tag, k), out, ev);
            for (int i = 0; i < CH; i++) if (out[i] === 1'b1) hi[i]++;
            @(negedge clk);
        end
        for (int i = 0; i < CH; i++) chk($sformatf("%s_high%0d", tag, i), hi[i], hexp[i]);
    endtask

    initial begin
        cseq = '{0, 1, 2, 3, 4, 3, 2, 1};
        for (int i = 0; i < CH; i++) duty_m[i] = 0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_period", period, 0);
        chk("rst_out", out, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_period", period, 1);
        chk("restart_count", count, 0);
        @(negedge clk);
        chk("restart_next_count", count, 1);
        chk("restart_next_period", period, 0);

        // Test 1: range 9, duty0 3
        wr(4, 9);
        wr(0, 3);
        wait_period(300);
        wait_period(20);
        range_m   = 9;
        duty_m[0] = 3;
        check_period("t1", 3, 0, 0, 0);

        // Test 2: duty extremes
        wr(1, 0);
        wr(2, 9);
        wr(3, 200);
        wait_period(20);
        wait_period(20);
        duty_m[1] = 0; duty_m[2] = 9; duty_m[3] = 200;
        check_period("t2", 3, 0, 9, 10);

        // Test 3: mid-period write holds until the boundary
        repeat (4) @(negedge clk);
        chk("t3_k4_count", count, 4);
        wr(0, 6);
        @(negedge clk);
        for (int k = 5; k <= 8; k++) begin
            chk($sformatf("t3_hold_cnt%0d", k), count, k);
            chk($sformatf("t3_hold_out%0d", k), out[0], 0);
            @(negedge clk);
        end
        // Write on the load edge lands in pending only
        chk("t3_k9_count", count, 9);
        wr(0, 2);
        @(negedge clk);
        duty_m[0] = 6;
        check_period("t3a", 6, 0, 9, 10);
        duty_m[0] = 2;
        check_period("t3b", 2, 0, 9, 10);

        // Test 4: range 0
        wr(4, 0);
        wait_period(20);
        wait_period(5);
        range_m = 0;
        repeat (3) check_period("t4", 1, 0, 1, 1);

        // Test 5: enable gating and mid-period reset
        wr(4, 9);
        wait_period(5);
        wait_period(5);
        wait_period(20);
        @(negedge clk);
        chk("t5_k1_count", count, 1);
        chk("t5_k1_out0", out[0], 1);
        en[0] = 1'b0;
        @(negedge clk);
        chk("t5_dis_out0", out[0], 0);
        chk("t5_dis_count", count, 2);
        en = '1;
        @(negedge clk);
        chk("t5_k3_count", count, 3);
        repeat (8) @(negedge clk);
        chk("t5_k1b_count", count, 1);
        chk("t5_k1b_out0", out[0], 1);
        rst = 1'b1;
        #1;
        chk("t5_arst_out", out, 0);
        chk("t5_arst_count", count, 0);
        chk("t5_arst_period", period, 0);
        @(negedge clk);
        chk("t5_hold_count", count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rel_period", period, 1);
        chk("t5_rel_count", count, 0);
        chk("t5_rel_out", out, 0);
        repeat (20) @(negedge clk);
        chk("t5_range255_count", count, 20);
        chk("t5_range255_period", period, 0);
        chk("t5_duty0_out", out, 0);

`ifdef PWM_CENTER_ALIGN_EN
        // Test 6: center-aligned, range 4, duty0 2
        center = 1'b1;
        wr(4, 4);
        wr(0, 2);
        wait_period(300);
        wait_period(20);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t6_cnt%0d", k), count, cseq[k]);
            chk($sformatf("t6_per%0d", k), period, (k == 0));
            chk($sformatf("t6_out%0d", k), out[0], (cseq[(k + 7) % 8] < 2));
            @(negedge clk);
        end
        chk("t6_wrap_count", count, 0);
        chk("t6_wrap_period", period, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
